swd_target_responder: RTL and testbench

- Target-side SWD endpoint: the other end of the probe's SWD initiator.
- Decodes host packet requests on SWCLK/SWDIO and drives turnaround, ACK, read data and parity.
- Captures write data and exposes a simple register-access handshake to a DP/AP register model.
- Used as the loopback/verification target for the probe's bit-serial engine.
- Is also synthesizable onto the fabric for board-level self-test.

---
 rtl/swd_target_responder.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_swd_target_responder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swd_target_responder.sv
`default_nettype none
// ============================================================================
//  Module   : swd_target_responder
//  Purpose  : Target-side SWD endpoint. Decodes host packet requests sampled
//             on SWCLK rising edges, drives turnaround/ACK/read data/parity,
//             captures write data and hands register accesses to a DP/AP
//             register model through a simple pulse handshake.
//  Ports    : clk, rst              - system clock, sync active-high reset
//             swclk, swdio_in       - SWD line inputs (already synchronized)
//             swdio_out, swdio_oe   - SWDIO drive value / drive enable
//             busy, fault           - ACK selection, sampled at request decode
//             req_ap, req_addr      - APnDP and A[3:2] of the latest request
//             rd_req, rd_data       - read request pulse / read value
//             wr_valid, wr_data     - write strobe / captured write data
//             wr_perr, req_err      - write parity error / malformed request
//             line_reset            - line reset detected
//  Revision : 1.0 - initial release
// ============================================================================
module swd_target_responder #(
    parameter logic [31:0] IDCODE          = 32'h0BA01477,
    parameter int          LINE_RESET_BITS = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        swclk,
    input  logic        swdio_in,
    output logic        swdio_out,
    output logic        swdio_oe,
    input  logic        busy,
    input  logic        fault,
    output logic        req_ap,
    output logic [1:0]  req_addr,
    output logic        rd_req,
    input  logic [31:0] rd_data,
    output logic        wr_valid,
    output logic [31:0] wr_data,
    output logic        wr_perr,
    output logic        req_err,
    output logic        line_reset
);

    localparam int                  c_ONES_W    = $clog2(LINE_RESET_BITS + 1);
    localparam logic [c_ONES_W-1:0] c_ONES_MAX  = c_ONES_W'(LINE_RESET_BITS);
    localparam logic [2:0]          c_ACK_OK    = 3'b001;
    localparam logic [2:0]          c_ACK_WAIT  = 3'b010;
    localparam logic [2:0]          c_ACK_FAULT = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_TRN1  = 3'd2,
        ST_ACK   = 3'd3,
        ST_RDATA = 3'd4,
        ST_WDATA = 3'd5
    } state_t;

    state_t              r_state,      w_state_nxt;
    logic [5:0]          r_bitcnt,     w_bitcnt_nxt;
    logic                r_armed,      w_armed_nxt;
    logic [c_ONES_W-1:0] r_ones,       w_ones_nxt;
    logic [5:0]          r_req,        w_req_nxt;     // request bits 1..6, LSB = bit 1
    logic                r_rnw,        w_rnw_nxt;
    logic [2:0]          r_ack,        w_ack_nxt;
    logic [31:0]         r_shift,      w_shift_nxt;
    logic                r_par,        w_par_nxt;
    logic                r_out,        w_out_nxt;
    logic                r_oe,         w_oe_nxt;
    logic                r_ap,         w_ap_nxt;
    logic [1:0]          r_addr,       w_addr_nxt;
    logic [31:0]         r_wdata,      w_wdata_nxt;
    logic                r_rd_req,     w_rd_req_nxt;
    logic                r_wr_valid,   w_wr_valid_nxt;
    logic                r_wr_perr,    w_wr_perr_nxt;
    logic                r_req_err,    w_req_err_nxt;
    logic                r_line_reset, w_line_reset_nxt;
    logic                r_swclk_q;

    logic        w_rise;
    logic        w_req_ok;
    logic        w_req_idcode;
    logic [31:0] w_rd_src;

    assign w_rise       = swclk & ~r_swclk_q;
    // Decoded on the park-bit rise: r_req holds bits 1..6, swdio_in is park.
    assign w_req_ok     = (r_req[4] == ^r_req[3:0]) && !r_req[5] && swdio_in;
    assign w_req_idcode = !r_req[0] && (r_req[3:2] == 2'b00);
    assign w_rd_src     = (!r_ap && (r_addr == 2'b00)) ? IDCODE : rd_data;

    always_comb begin
        w_state_nxt      = r_state;
        w_bitcnt_nxt     = r_bitcnt;
        w_armed_nxt      = r_armed;
        w_ones_nxt       = r_ones;
        w_req_nxt        = r_req;
        w_rnw_nxt        = r_rnw;
        w_ack_nxt        = r_ack;
        w_shift_nxt      = r_shift;
        w_par_nxt        = r_par;
        w_out_nxt        = r_out;
        w_oe_nxt         = r_oe;
        w_ap_nxt         = r_ap;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_rd_req_nxt     = 1'b0;
        w_wr_valid_nxt   = 1'b0;
        w_wr_perr_nxt    = 1'b0;
        w_req_err_nxt    = 1'b0;
        w_line_reset_nxt = 1'b0;

        if (w_rise) begin
            case (r_state)
                ST_IDLE: begin
                    if (!swdio_in) begin
                        w_armed_nxt = 1'b1;
                    end else if (r_armed) begin
                        w_state_nxt  = ST_REQ;
                        w_bitcnt_nxt = 6'd1;
                    end
                end
                ST_REQ: begin
                    w_req_nxt    = {swdio_in, r_req[5:1]};
                    w_bitcnt_nxt = r_bitcnt + 6'd1;
                    if (r_bitcnt == 6'd7) begin
                        if (w_req_ok) begin
                            w_ap_nxt    = r_req[0];
                            w_rnw_nxt   = r_req[1];
                            w_addr_nxt  = r_req[3:2];
                            w_ack_nxt   = fault ? c_ACK_FAULT : (busy ? c_ACK_WAIT : c_ACK_OK);
                            // DP IDCODE is answered locally, so no register-model read.
                            w_rd_req_nxt = !fault && !busy && r_req[1] && !w_req_idcode;
                            w_state_nxt  = ST_TRN1;
                        end else begin
                            w_req_err_nxt = 1'b1;
                            w_armed_nxt   = 1'b0;
                            w_state_nxt   = ST_IDLE;
                        end
                    end
                end
                ST_TRN1: begin
                    w_oe_nxt     = 1'b1;
                    w_out_nxt    = r_ack[0];
                    w_bitcnt_nxt = 6'd1;
                    w_state_nxt  = ST_ACK;
                end
                ST_ACK: begin
                    if (r_bitcnt < 6'd3) begin
                        w_out_nxt    = r_ack[r_bitcnt[1:0]];
                        w_bitcnt_nxt = r_bitcnt + 6'd1;
                    end else if ((r_ack == c_ACK_OK) && r_rnw) begin
                        w_out_nxt    = w_rd_src[0];
                        w_shift_nxt  = {1'b0, w_rd_src[31:1]};
                        w_par_nxt    = ^w_rd_src;
                        w_bitcnt_nxt = 6'd1;
                        w_state_nxt  = ST_RDATA;
                    end else if (r_ack == c_ACK_OK) begin
                        w_oe_nxt     = 1'b0;
                        w_out_nxt    = 1'b0;
                        w_bitcnt_nxt = 6'd0;
                        w_state_nxt  = ST_WDATA;
                    end else begin
                        w_oe_nxt    = 1'b0;
                        w_out_nxt   = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_RDATA: begin
                    if (r_bitcnt < 6'd32) begin
                        w_out_nxt    = r_shift[0];
                        w_shift_nxt  = {1'b0, r_shift[31:1]};
                        w_bitcnt_nxt = r_bitcnt + 6'd1;
                    end else if (r_bitcnt == 6'd32) begin
                        w_out_nxt    = r_par;
                        w_bitcnt_nxt = r_bitcnt + 6'd1;
                    end else begin
                        w_oe_nxt    = 1'b0;
                        w_out_nxt   = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_WDATA: begin
                    if (r_bitcnt < 6'd32) begin
                        w_shift_nxt  = {swdio_in, r_shift[31:1]};
                        w_bitcnt_nxt = r_bitcnt + 6'd1;
                    end else begin
                        // Data is captured even on a parity error.
                        w_wdata_nxt    = r_shift;
                        w_wr_valid_nxt = (swdio_in == ^r_shift);
                        w_wr_perr_nxt  = (swdio_in != ^r_shift);
                        w_state_nxt    = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            // Line-reset detection overrides whatever the packet phase decided.
            // Samples taken while we drive the line are our own and are ignored.
            if (!r_oe) begin
                if (swdio_in) begin
                    if (r_ones != c_ONES_MAX) begin
                        w_ones_nxt = r_ones + 1'b1;
                    end
                    if (r_ones == c_ONES_MAX - 1'b1) begin
                        w_line_reset_nxt = 1'b1;
                        w_oe_nxt         = 1'b0;
                        w_out_nxt        = 1'b0;
                        w_armed_nxt      = 1'b0;
                        w_bitcnt_nxt     = 6'd0;
                        w_state_nxt      = ST_IDLE;
                        w_rd_req_nxt     = 1'b0;
                        w_wr_valid_nxt   = 1'b0;
                        w_wr_perr_nxt    = 1'b0;
                        w_req_err_nxt    = 1'b0;
                    end
                end else begin
                    w_ones_nxt = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // Tracking swclk through reset avoids a false rise on reset release.
        r_swclk_q <= swclk;
        if (rst) begin
            r_state      <= ST_IDLE;
            r_bitcnt     <= '0;
            r_armed      <= 1'b0;
            r_ones       <= '0;
            r_req        <= '0;
            r_rnw        <= 1'b0;
            r_ack        <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_out        <= 1'b0;
            r_oe         <= 1'b0;
            r_ap         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rd_req     <= 1'b0;
            r_wr_valid   <= 1'b0;
            r_wr_perr    <= 1'b0;
            r_req_err    <= 1'b0;
            r_line_reset <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_armed      <= w_armed_nxt;
            r_ones       <= w_ones_nxt;
            r_req        <= w_req_nxt;
            r_rnw        <= w_rnw_nxt;
            r_ack        <= w_ack_nxt;
            r_shift      <= w_shift_nxt;
            r_par        <= w_par_nxt;
            r_out        <= w_out_nxt;
            r_oe         <= w_oe_nxt;
            r_ap         <= w_ap_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_rd_req     <= w_rd_req_nxt;
            r_wr_valid   <= w_wr_valid_nxt;
            r_wr_perr    <= w_wr_perr_nxt;
            r_req_err    <= w_req_err_nxt;
            r_line_reset <= w_line_reset_nxt;
        end
    end

    assign swdio_out  = r_out;
    assign swdio_oe   = r_oe;
    assign req_ap     = r_ap;
    assign req_addr   = r_addr;
    assign rd_req     = r_rd_req;
    assign wr_valid   = r_wr_valid;
    assign wr_data    = r_wdata;
    assign wr_perr    = r_wr_perr;
    assign req_err    = r_req_err;
    assign line_reset = r_line_reset;

endmodule
`default_nettype wire

// File: tb/tb_swd_target_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_swd_target_responder
//  Purpose  : Directed self-checking bench for swd_target_responder. Acts as
//             the SWD host: each SWCLK period is 8 clk cycles, data is set
//             while SWCLK is low and target outputs are read late in the high
//             phase.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_swd_target_responder;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        swclk    = 1'b0;
    logic        swdio_in = 1'b0;
    logic        busy     = 1'b0;
    logic        fault    = 1'b0;
    logic [31:0] rd_data  = 32'h0;
    logic        swdio_out, swdio_oe, req_ap, rd_req, wr_valid, wr_perr, req_err, line_reset;
    logic [1:0]  req_addr;
    logic [31:0] wr_data;

    int tests  = 0;
    int failed = 0;

    // Pulse / activity counters
    int n_rd = 0, n_wv = 0, n_perr = 0, n_rerr = 0, n_lr = 0, n_oe = 0;
    int s_rd, s_wv, s_perr, s_rerr, s_lr, s_oe;

    swd_target_responder dut (
        .clk        (clk),
        .rst        (rst),
        .swclk      (swclk),
        .swdio_in   (swdio_in),
        .swdio_out  (swdio_out),
        .swdio_oe   (swdio_oe),
        .busy       (busy),
        .fault      (fault),
        .req_ap     (req_ap),
        .req_addr   (req_addr),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_perr    (wr_perr),
        .req_err    (req_err),
        .line_reset (line_reset)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_req)     n_rd++;
        if (wr_valid)   n_wv++;
        if (wr_perr)    n_perr++;
        if (req_err)    n_rerr++;
        if (line_reset) n_lr++;
        if (swdio_oe)   n_oe++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_rd = n_rd; s_wv = n_wv; s_perr = n_perr;
        s_rerr = n_rerr; s_lr = n_lr; s_oe = n_oe;
    endtask

    // One SWCLK period: host bit set while low, target outputs read after the rise.
    task automatic swd_cycle(input logic din, output logic dout, output logic doe);
        @(negedge clk);
        swdio_in = din;
        swclk    = 1'b0;
        repeat (3) @(negedge clk);
        swclk = 1'b1;
        repeat (4) @(negedge clk);
        dout = swdio_out;
        doe  = swdio_oe;
    endtask

    task automatic idle(input int n);
        logic d, o;
        for (int i = 0; i < n; i++) swd_cycle(1'b0, d, o);
    endtask

    task automatic send_req(input logic [7:0] r);
        logic d, o;
        for (int i = 0; i < 8; i++) swd_cycle(r[i], d, o);
    endtask

    // Turnaround rise plus the two following rises return ack[0..2].
    task automatic get_ack(output logic [2:0] ack, output logic oe_all);
        logic d, o;
        oe_all = 1'b1;
        for (int i = 0; i < 3; i++) begin
            swd_cycle(1'b0, d, o);
            ack[i] = d;
            oe_all &= o;
        end
    endtask

    task automatic read_data(output logic [31:0] data, output logic par, output logic oe_all);
        logic d, o;
        oe_all = 1'b1;
        for (int i = 0; i < 32; i++) begin
            swd_cycle(1'b0, d, o);
            data[i] = d;
            oe_all &= o;
        end
        swd_cycle(1'b0, d, o);
        par = d;
        oe_all &= o;
    endtask

    task automatic write_data(input logic [31:0] data, input logic par);
        logic d, o;
        for (int i = 0; i < 32; i++) swd_cycle(data[i], d, o);
        swd_cycle(par, d, o);
    endtask

    logic [2:0]  ack;
    logic [31:0] rdat;
    logic        par, oe_all, dq, oq, oe_any;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ctl", {29'd0, swdio_oe, swdio_out, req_ap, req_addr, rd_req,
                            wr_valid, wr_perr, req_err, line_reset}, 32'h0);
        check("reset_wr_data", wr_data, 32'h0);
        rst = 1'b0;

        // DP IDCODE read
        snap();
        idle(4);
        send_req(8'hA5);
        get_ack(ack, oe_all);
        check("idc_ack", {29'd0, ack}, 32'h1);
        check("idc_ack_oe", {31'd0, oe_all}, 32'h1);
        read_data(rdat, par, oe_all);
        check("idc_data", rdat, 32'h0BA01477);
        check("idc_par", {31'd0, par}, 32'h1);
        check("idc_data_oe", {31'd0, oe_all}, 32'h1);
        swd_cycle(1'b0, dq, oq);
        check("idc_trn_oe", {31'd0, oq}, 32'h0);
        check("idc_no_rdreq", n_rd - s_rd, 32'h0);

        // AP write A[3:2]=1 with a bad parity bit: data captured, error flagged
        snap();
        idle(2);
        send_req(8'h8B);
        get_ack(ack, oe_all);
        check("wperr_ack", {29'd0, ack}, 32'h1);
        swd_cycle(1'b0, dq, oq);
        check("wperr_trn_oe", {31'd0, oq}, 32'h0);
        write_data(32'h12345678, 1'b0);
        check("wperr_perr", n_perr - s_perr, 32'h1);
        check("wperr_no_valid", n_wv - s_wv, 32'h0);
        check("wperr_wr_data", wr_data, 32'h12345678);

        // Same write with correct parity
        snap();
        idle(2);
        send_req(8'h8B);
        get_ack(ack, oe_all);
        check("wr_ack", {29'd0, ack}, 32'h1);
        swd_cycle(1'b0, dq, oq);
        write_data(32'h12345678, 1'b1);
        check("wr_valid", n_wv - s_wv, 32'h1);
        check("wr_no_perr", n_perr - s_perr, 32'h0);
        check("wr_data", wr_data, 32'h12345678);
        check("wr_req_ap", {31'd0, req_ap}, 32'h1);
        check("wr_req_addr", {30'd0, req_addr}, 32'h1);

        // AP read A[3:2]=1 served from rd_data
        snap();
        rd_data = 32'hDEADBEEF;
        idle(2);
        send_req(8'hAF);
        get_ack(ack, oe_all);
        check("apr_ack", {29'd0, ack}, 32'h1);
        check("apr_rdreq", n_rd - s_rd, 32'h1);
        read_data(rdat, par, oe_all);
        check("apr_data", rdat, 32'hDEADBEEF);
        check("apr_par", {31'd0, par}, 32'h0);
        swd_cycle(1'b0, dq, oq);
        check("apr_trn_oe", {31'd0, oq}, 32'h0);

        // AP read A[3:2]=3 while busy; busy drops right after decode
        snap();
        busy = 1'b1;
        idle(2);
        send_req(8'h9F);
        busy = 1'b0;
        get_ack(ack, oe_all);
        check("wait_ack", {29'd0, ack}, 32'h2);
        swd_cycle(1'b0, dq, oq);
        check("wait_trn_oe", {31'd0, oq}, 32'h0);
        s_oe = n_oe;
        idle(4);
        check("wait_no_data", n_oe - s_oe, 32'h0);
        check("wait_no_rdreq", n_rd - s_rd, 32'h0);
        check("wait_req_addr", {30'd0, req_addr}, 32'h3);

        // FAULT has priority over busy
        fault = 1'b1;
        busy  = 1'b1;
        idle(2);
        send_req(8'hA5);
        fault = 1'b0;
        busy  = 1'b0;
        get_ack(ack, oe_all);
        check("fault_ack", {29'd0, ack}, 32'h4);
        swd_cycle(1'b0, dq, oq);
        check("fault_trn_oe", {31'd0, oq}, 32'h0);

        // Stop bit set: malformed request, line never driven
        snap();
        idle(2);
        send_req(8'hE5);
        idle(4);
        check("bad_req_err", n_rerr - s_rerr, 32'h1);
        check("bad_no_oe", n_oe - s_oe, 32'h0);
        idle(2);
        send_req(8'hA5);
        get_ack(ack, oe_all);
        read_data(rdat, par, oe_all);
        check("bad_then_idc", rdat, 32'h0BA01477);
        swd_cycle(1'b0, dq, oq);

        // 50 ones starting at the first write data bit
        snap();
        idle(2);
        send_req(8'h8B);
        get_ack(ack, oe_all);
        swd_cycle(1'b0, dq, oq);
        oe_any = 1'b0;
        for (int i = 0; i < 50; i++) begin
            swd_cycle(1'b1, dq, oq);
            oe_any |= oq;
        end
        check("lr_pulse", n_lr - s_lr, 32'h1);
        check("lr_no_valid", n_wv - s_wv, 32'h0);
        check("lr_oe", {31'd0, oe_any}, 32'h0);
        idle(2);
        send_req(8'hA5);
        get_ack(ack, oe_all);
        check("lr_idc_ack", {29'd0, ack}, 32'h1);
        read_data(rdat, par, oe_all);
        check("lr_idc_data", rdat, 32'h0BA01477);
        swd_cycle(1'b0, dq, oq);

        // Reset in the middle of a read data phase
        idle(2);
        send_req(8'hA5);
        get_ack(ack, oe_all);
        for (int i = 0; i < 5; i++) swd_cycle(1'b0, dq, oq);
        check("rst_pre_oe", {31'd0, swdio_oe}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_oe_drop", {31'd0, swdio_oe}, 32'h0);
        rst = 1'b0;
        idle(2);
        send_req(8'hA5);
        get_ack(ack, oe_all);
        read_data(rdat, par, oe_all);
        check("rst_then_idc", rdat, 32'h0BA01477);
        swd_cycle(1'b0, dq, oq);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
